// File: rtl/mux_dff_arbiter_if.sv
// Handshake bundle between two requesters, the shared mux-flop arbiter and its consumer.
// The master side drives requests and out_ready; the slave side is the arbiter.
interface mux_dff_arbiter_if #(
  parameter int WIDTH = 1
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_last;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_last;
  logic             req1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_src;
  logic             out_ready;
  logic             sel;
  logic             busy;

  modport master (
    output req0_valid, req0_data, req0_last,
    output req1_valid, req1_data, req1_last,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_data, out_last, out_src, sel, busy
  );

  modport slave (
    input  req0_valid, req0_data, req0_last,
    input  req1_valid, req1_data, req1_last,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_data, out_last, out_src, sel, busy
  );
endinterface

// File: rtl/mux_dff_arbiter.sv
// Two-requester round-robin packet arbiter feeding a registered 2:1 mux-flop.
// A grant stays locked from a packet's first beat until its last beat is accepted.
module mux_dff_arbiter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  mux_dff_arbiter_if.slave bus
);
  // state | meaning
  // IDLE  | no packet in flight; round-robin chooses the next winner
  // LOCK0 | requester 0 mid-packet; requester 1 blocked
  // LOCK1 | requester 1 mid-packet; requester 0 blocked
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             rr_last_q, rr_last_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             out_src_q, out_src_d;

  logic             sel;
  logic             can_accept;
  logic             ready0, ready1;
  logic             accept;
  logic [WIDTH-1:0] mux_data;
  logic             mux_last;

  always_comb begin
    sel = rr_last_q;
    case (state_q)
      LOCK0:   sel = 1'b0;
      LOCK1:   sel = 1'b1;
      default: begin
        if (bus.req0_valid && !bus.req1_valid)      sel = 1'b0;
        else if (bus.req1_valid && !bus.req0_valid) sel = 1'b1;
        else if (bus.req0_valid && bus.req1_valid)  sel = !rr_last_q;
        else                                        sel = rr_last_q;
      end
    endcase
  end

  // Readies are held low while reset is asserted so nothing looks accepted.
  always_comb begin
    can_accept = !out_valid_q || bus.out_ready;
    ready0     = rst && can_accept && !sel && (state_q == IDLE || state_q == LOCK0);
    ready1     = rst && can_accept &&  sel && (state_q == IDLE || state_q == LOCK1);
    accept     = (bus.req0_valid && ready0) || (bus.req1_valid && ready1);
    mux_data   = sel ? bus.req1_data : bus.req0_data;
    mux_last   = sel ? bus.req1_last : bus.req0_last;
  end

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_last_d  = mux_last;
      out_src_d   = sel;
      rr_last_d   = sel;
      if (mux_last)  state_d = IDLE;
      else if (sel)  state_d = LOCK1;
      else           state_d = LOCK0;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_last_q   <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_src    = out_src_q;
  assign bus.sel        = sel;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mux_dff_arbiter.sv
// Directed bench for mux_dff_arbiter: expected beats are queued when a scenario starts,
// a monitor pops and compares on each output handshake; per-cycle readies are checked inline.
module tb_mux_dff_arbiter;
  localparam int WIDTH = 1;

  typedef struct packed {
    logic             src;
    logic             last;
    logic [WIDTH-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  mux_dff_arbiter_if #(.WIDTH(WIDTH)) bus ();
  mux_dff_arbiter #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic src, input logic last, input logic [WIDTH-1:0] data);
    beat_t b;
    b.src = src; b.last = last; b.data = data;
    exp_q.push_back(b);
  endtask

  // One cycle of stimulus plus the readies/busy/out_valid expected during that cycle.
  task automatic step(input string nm,
                      input logic v0, input logic [WIDTH-1:0] d0, input logic l0,
                      input logic v1, input logic [WIDTH-1:0] d1, input logic l1,
                      input logic ordy,
                      input logic er0, input logic er1, input logic eb, input logic eov);
    @(negedge clk);
    bus.req0_valid = v0; bus.req0_data = d0; bus.req0_last = l0;
    bus.req1_valid = v1; bus.req1_data = d1; bus.req1_last = l1;
    bus.out_ready  = ordy;
    #2;
    check({nm, "_ready0"},    32'(bus.req0_ready), 32'(er0));
    check({nm, "_ready1"},    32'(bus.req1_ready), 32'(er1));
    check({nm, "_busy"},      32'(bus.busy),       32'(eb));
    check({nm, "_out_valid"}, 32'(bus.out_valid),  32'(eov));
  endtask

  initial begin : monitor
    beat_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got src=%0d data=%0h, expected no beat", bus.out_src, bus.out_data);
        end else begin
          e = exp_q.pop_front();
          check("beat_src",  32'(bus.out_src),  32'(e.src));
          check("beat_last", 32'(bus.out_last), 32'(e.last));
          check("beat_data", 32'(bus.out_data), 32'(e.data));
        end
      end
    end
  end

  initial begin : stimulus
    bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_last = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_last = 1'b0;
    bus.out_ready  = 1'b0;
    rst = 1'b0;

    // reset held with both requesters valid
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.out_ready = 1'b1;
    bus.req0_data = 1'b1; bus.req0_last = 1'b1; bus.req1_last = 1'b1;
    #2;
    check("rst_ready0",    32'(bus.req0_ready), 0);
    check("rst_ready1",    32'(bus.req1_ready), 0);
    check("rst_out_valid", 32'(bus.out_valid),  0);
    check("rst_out_data",  32'(bus.out_data),   0);
    check("rst_out_last",  32'(bus.out_last),   0);
    check("rst_out_src",   32'(bus.out_src),    0);
    check("rst_busy",      32'(bus.busy),       0);
    @(negedge clk);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    rst = 1'b1;

    // tie alternation, single-beat packets, no bubbles
    push(0, 1, 1); push(1, 1, 0); push(0, 1, 1); push(1, 1, 0);
    step("tie0",  1,1,1, 1,0,1, 1,  1,0,0,0);
    step("tie1",  1,1,1, 1,0,1, 1,  0,1,0,1);
    step("tie2",  1,1,1, 1,0,1, 1,  1,0,0,1);
    step("tie3",  1,1,1, 1,0,1, 1,  0,1,0,1);
    step("tie_d", 0,0,0, 0,0,0, 1,  0,1,0,1);

    // requester 1 three-beat packet locks out a continuously valid requester 0
    push(0, 1, 0); push(1, 0, 1); push(1, 0, 1); push(1, 1, 0); push(0, 1, 0);
    step("lk1",   1,0,1, 0,0,0, 1,  1,0,0,0);
    step("lk2",   1,0,1, 1,1,0, 1,  0,1,0,1);
    step("lk3",   1,0,1, 1,1,0, 1,  0,1,1,1);
    step("lk4",   1,0,1, 1,0,1, 1,  0,1,1,1);
    step("lk5",   1,0,1, 0,0,0, 1,  1,0,0,1);
    step("lk6",   0,0,0, 0,0,0, 1,  1,0,0,1);

    // requester 0 locked, idles two cycles while requester 1 waits
    push(0, 0, 1); push(0, 1, 0); push(1, 1, 1);
    step("bb1",   1,1,0, 0,0,0, 1,  1,0,0,0);
    step("bb2",   0,0,0, 1,1,1, 1,  1,0,1,1);
    step("bb3",   0,0,0, 1,1,1, 1,  1,0,1,0);
    step("bb4",   1,0,1, 1,1,1, 1,  1,0,1,0);
    step("bb5",   0,0,0, 1,1,1, 1,  0,1,0,1);
    step("bb6",   0,0,0, 0,0,0, 1,  0,1,0,1);

    // backpressure for four cycles, then drain and accept in the same cycle
    push(0, 1, 1); push(1, 1, 0);
    step("bp1",   1,1,1, 0,0,0, 0,  1,0,0,0);
    for (int i = 0; i < 4; i++) begin
      step("bp_hold", 1,0,1, 1,0,1, 0,  0,0,0,1);
      check("bp_data_stable", 32'(bus.out_data), 1);
    end
    step("bp6",   1,0,1, 1,0,1, 1,  0,1,0,1);
    step("bp7",   0,0,0, 0,0,0, 1,  0,1,0,1);

    // reset asserted after the first beat of a packet
    step("rm1",   1,1,0, 0,0,0, 0,  1,0,0,0);
    @(negedge clk);
    #1;
    check("rm_pre_busy",      32'(bus.busy),      1);
    check("rm_pre_out_valid", 32'(bus.out_valid), 1);
    #2;
    rst = 1'b0;
    #1;
    check("rm_out_valid", 32'(bus.out_valid),  0);
    check("rm_busy",      32'(bus.busy),       0);
    check("rm_out_data",  32'(bus.out_data),   0);
    check("rm_ready0",    32'(bus.req0_ready), 0);
    @(negedge clk);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    rst = 1'b1;
    push(0, 1, 1);
    step("rm2",   1,1,1, 1,0,1, 1,  1,0,0,0);
    step("rm3",   0,0,0, 0,0,0, 1,  1,0,0,1);

    @(negedge clk);
    #2;
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_dff_arbiter.md
# mux_dff_arbiter

Two-requester packet arbiter that shares a registered 2:1 mux-flop datapath between two sources. It selects one requester per beat, drives the mux select, and captures the winning data into a single output register with a valid/ready handshake. Arbitration is round-robin between packets, and a grant stays locked for the whole multi-beat packet. It sits in front of any consumer that previously took the raw mux-flop output.

## Interface
- WIDTH, 1: data width of each requester and of the output register
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low (asserted when 0)
- req0_valid  input  1  requester 0 has a beat
- req0_data  input  WIDTH  requester 0 beat data
- req0_last  input  1  beat is the final beat of requester 0's packet
- req0_ready  output  1  requester 0 beat accepted this cycle when high with req0_valid
- req1_valid / req1_data / req1_last / req1_ready: same as requester 0, for requester 1
- out_valid  output  1  out_data holds an unconsumed beat
- out_data  output  WIDTH  registered beat
- out_last  output  1  registered copy of the accepted beat's last flag
- out_src  output  1  registered source of the beat in out_data (0 or 1)
- sel  output  1  combinational mux select for the current cycle (current winner)
- busy  output  1  high while a packet is locked (state LOCK0 or LOCK1)

## Operation
- FSM states: IDLE, LOCK0, LOCK1. Round-robin pointer rr_last holds the last-granted requester.
- can_accept = !out_valid | out_ready.
- Winner selection:
  - LOCK0 selects 0; LOCK1 selects 1.
  - In IDLE with only one valid, that requester wins.
  - In IDLE with both valid, the requester != rr_last wins.
  - In IDLE with neither valid, sel = rr_last (don't-care, fixed for determinism).
- reqN_ready = can_accept & (sel == N) & (the state is IDLE or LOCKN). The ready of the non-winner is always 0.
- Accept of requester N (reqN_valid & reqN_ready), on the next clk:
  - out_data <= reqN_data, out_last <= reqN_last, out_src <= N, out_valid <= 1.
  - rr_last <= N.
  - If reqN_last = 0, state <= LOCKN; if 1, state <= IDLE.
- No accept but out_ready & out_valid: out_valid <= 0. out_data, out_last and out_src hold their values.
- No accept and no drain: all registers hold.
- In LOCKN, the locked requester idling (valid low) produces bubbles. The other requester stays blocked until requester N's last beat is accepted; there is no timeout.
- The data path is equivalent to the mux-flop: sel picks reqN_data, and the register loads it on accept.

## Timing
- Reset (rst = 0, asynchronous): state IDLE, rr_last = 1 (requester 0 wins the first tie), out_valid = 0, out_data = 0, out_last = 0, out_src = 0, busy = 0.
- Reset release is synchronous to clk, and the first accept is possible on the first edge after release.
- Latency: a beat accepted at edge k is visible on out_* after edge k, i.e. 1 cycle.
- Throughput: 1 beat/cycle while out_ready = 1, including back-to-back packets from alternating requesters (IDLE → IDLE switches with no bubble).
- Backpressure: if out_valid = 1 and out_ready = 0, both readies are 0 and the state, pointer and outputs hold.
- Simultaneous drain and accept in one cycle: the output register is overwritten by the new beat and out_valid stays 1.
- A single-beat packet (last = 1 on the first beat) never leaves IDLE.
- Reset during a locked packet: returns to IDLE, the partial packet is dropped, and out_valid = 0 immediately.
- Ready is combinational from the valids, state and out_ready. No output depends combinationally on out_data.

## Test plan
- Reset: hold rst = 0 with both valids high → out_valid = 0, out_data = 0, readies = 0, busy = 0. Release → first accept goes to requester 0 (rr_last = 1).
- Tie alternation: both requesters send single-beat packets (data 0 = 1, data 1 = 0, last = 1), out_ready = 1 → out_src sequence 0,1,0,1 with out_data 1,0,1,0 on consecutive cycles and no bubbles.
- Packet lock: requester 1 sends 3 beats (1,1,0; last on the third) while requester 0 is continuously valid → req0_ready = 0 for those 3 cycles, out_src = 1 ×3, busy = 1 until the last beat is accepted, then requester 0 is granted next.
- Lock with bubble: requester 0 locked, drops valid for 2 cycles mid-packet while requester 1 is valid → out_valid = 0 for 2 cycles after draining, req1_ready = 0 throughout, and requester 0 resumes.
- Backpressure: out_ready = 0 with out_valid = 1 for 4 cycles → readies = 0 and out_data stable. Raise out_ready with a pending beat → drain and accept in the same cycle, out_valid stays 1 with the new data.
- Reset mid-packet: assert rst after beat 1 of a 3-beat packet → state IDLE, out_valid = 0 at once. After release, a tie goes to requester 0.
